// File: rtl/trace_capture_sequencer.sv
// Trigger sequencer for the CW305 trace capture path: arms on host request, fires a
// programmable-length trigger pulse on a fresh edge of the selected source, then holds off.
module trace_capture_sequencer #(
    parameter int pLEN_WIDTH   = 16,
    parameter int pCOUNT_WIDTH = 8
) (
    input  logic                    trace_clk,
    input  logic                    reset,
    input  logic                    I_arm,
    input  logic                    I_disarm,
    input  logic                    I_source_sel,
    input  logic                    I_m3_trig,
    input  logic                    I_trace_trig,
    input  logic [pLEN_WIDTH-1:0]   I_trig_len,
    input  logic [pLEN_WIDTH-1:0]   I_holdoff,
    input  logic                    I_auto_rearm,
    input  logic                    I_clear_count,
    output logic                    O_trig_out,
    output logic                    O_armed,
    output logic                    O_busy,
    output logic [pCOUNT_WIDTH-1:0] O_capture_count
);

    typedef enum logic [1:0] {IDLE, ARMED, FIRE, HOLDOFF} state_t;

    localparam logic [pLEN_WIDTH-1:0]   LEN_ONE   = 1;
    localparam logic [pCOUNT_WIDTH-1:0] COUNT_ONE = 1;

    state_t                  state, next_state;
    logic [pLEN_WIDTH-1:0]   cycle_count, next_cycle_count;
    logic [pLEN_WIDTH-1:0]   holdoff_latched, next_holdoff;
    logic [pCOUNT_WIDTH-1:0] next_capture_count;
    logic                    m3_hist, trace_hist;
    logic                    trig_edge, fire_start;

    // Each source keeps its own history, so switching the select never fabricates an edge.
    assign trig_edge = I_source_sel ? (I_trace_trig & ~trace_hist)
                                    : (I_m3_trig & ~m3_hist);

    always_comb begin
        next_state       = state;
        next_cycle_count = cycle_count;
        next_holdoff     = holdoff_latched;
        fire_start       = 1'b0;
        case (state)
            IDLE: begin
                if (I_arm && !I_disarm)
                    next_state = ARMED;
            end
            ARMED: begin
                if (I_disarm) begin
                    next_state = IDLE;
                end else if (trig_edge) begin
                    next_state       = FIRE;
                    fire_start       = 1'b1;
                    next_cycle_count = (I_trig_len == '0) ? '0 : I_trig_len - LEN_ONE;
                    next_holdoff     = I_holdoff;
                end
            end
            FIRE: begin
                if (I_disarm) begin
                    next_state = IDLE;
                end else if (cycle_count == '0) begin
                    if (holdoff_latched != '0) begin
                        next_state       = HOLDOFF;
                        next_cycle_count = holdoff_latched - LEN_ONE;
                    end else begin
                        next_state = I_auto_rearm ? ARMED : IDLE;
                    end
                end else begin
                    next_cycle_count = cycle_count - LEN_ONE;
                end
            end
            HOLDOFF: begin
                if (I_disarm)
                    next_state = IDLE;
                else if (cycle_count == '0)
                    next_state = I_auto_rearm ? ARMED : IDLE;
                else
                    next_cycle_count = cycle_count - LEN_ONE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Clear takes effect before the increment, so a clear on a fire cycle leaves 1.
    always_comb begin
        next_capture_count = I_clear_count ? '0 : O_capture_count;
        if (fire_start && (next_capture_count != '1))
            next_capture_count = next_capture_count + COUNT_ONE;
    end

    always_ff @(posedge trace_clk) begin
        if (reset) begin
            state           <= IDLE;
            cycle_count     <= '0;
            holdoff_latched <= '0;
            m3_hist         <= 1'b0;
            trace_hist      <= 1'b0;
            O_trig_out      <= 1'b0;
            O_armed         <= 1'b0;
            O_busy          <= 1'b0;
            O_capture_count <= '0;
        end else begin
            state           <= next_state;
            cycle_count     <= next_cycle_count;
            holdoff_latched <= next_holdoff;
            m3_hist         <= I_m3_trig;
            trace_hist      <= I_trace_trig;
            O_trig_out      <= (next_state == FIRE);
            O_armed         <= (next_state == ARMED);
            O_busy          <= (next_state == FIRE) || (next_state == HOLDOFF);
            O_capture_count <= next_capture_count;
        end
    end

endmodule

// File: tb/tb_trace_capture_sequencer.sv
// Directed self-checking bench for trace_capture_sequencer: every step drives inputs
// just after a rising edge and checks the registered outputs one cycle later.
module tb_trace_capture_sequencer;

    logic        trace_clk = 1'b0;
    logic        reset;
    logic        I_arm, I_disarm, I_source_sel, I_m3_trig, I_trace_trig;
    logic [15:0] I_trig_len, I_holdoff;
    logic        I_auto_rearm, I_clear_count;
    logic        O_trig_out, O_armed, O_busy;
    logic [7:0]  O_capture_count;

    int errors = 0;
    int checks = 0;

    trace_capture_sequencer #(
        .pLEN_WIDTH  (16),
        .pCOUNT_WIDTH(8)
    ) dut (
        .trace_clk      (trace_clk),
        .reset          (reset),
        .I_arm          (I_arm),
        .I_disarm       (I_disarm),
        .I_source_sel   (I_source_sel),
        .I_m3_trig      (I_m3_trig),
        .I_trace_trig   (I_trace_trig),
        .I_trig_len     (I_trig_len),
        .I_holdoff      (I_holdoff),
        .I_auto_rearm   (I_auto_rearm),
        .I_clear_count  (I_clear_count),
        .O_trig_out     (O_trig_out),
        .O_armed        (O_armed),
        .O_busy         (O_busy),
        .O_capture_count(O_capture_count)
    );

    always #5 trace_clk = ~trace_clk;

    task automatic tick();
        @(posedge trace_clk);
        #1;
    endtask

    // Drive one cycle of stimulus; arm/disarm/clear are single-cycle pulses.
    task automatic applyStimulus(input logic arm, input logic disarm,
                                 input logic m3, input logic trace);
        I_arm        = arm;
        I_disarm     = disarm;
        I_m3_trig    = m3;
        I_trace_trig = trace;
        tick();
        I_arm         = 1'b0;
        I_disarm      = 1'b0;
        I_clear_count = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    initial begin
        reset         = 1'b1;
        I_arm         = 1'b0;
        I_disarm      = 1'b0;
        I_source_sel  = 1'b0;
        I_m3_trig     = 1'b0;
        I_trace_trig  = 1'b0;
        I_trig_len    = 16'd5;
        I_holdoff     = 16'd0;
        I_auto_rearm  = 1'b0;
        I_clear_count = 1'b0;
        tick();
        tick();
        checkOutput("reset_trig", O_trig_out, 0);
        checkOutput("reset_armed", O_armed, 0);
        checkOutput("reset_busy", O_busy, 0);
        checkOutput("reset_count", O_capture_count, 0);
        reset = 1'b0;

        // Basic fire: 5-cycle pulse, length change mid-pulse has no effect
        applyStimulus(1, 0, 0, 0);
        checkOutput("basic_armed", O_armed, 1);
        applyStimulus(0, 0, 1, 0);
        checkOutput("basic_trig_c1", O_trig_out, 1);
        checkOutput("basic_busy_c1", O_busy, 1);
        checkOutput("basic_armed_c1", O_armed, 0);
        checkOutput("basic_count", O_capture_count, 1);
        I_trig_len = 16'd1;
        for (int i = 2; i <= 5; i++) begin
            applyStimulus(0, 0, 1, 0);
            checkOutput("basic_trig_hold", O_trig_out, 1);
        end
        applyStimulus(0, 0, 1, 0);
        checkOutput("basic_trig_end", O_trig_out, 0);
        checkOutput("basic_idle_armed", O_armed, 0);
        checkOutput("basic_idle_busy", O_busy, 0);
        checkOutput("basic_count_end", O_capture_count, 1);

        // Zero length acts as a single-cycle pulse
        I_trig_len = 16'd0;
        applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 0, 1, 0);
        checkOutput("len0_trig", O_trig_out, 1);
        checkOutput("len0_count", O_capture_count, 2);
        applyStimulus(0, 0, 1, 0);
        checkOutput("len0_trig_end", O_trig_out, 0);
        checkOutput("len0_idle", O_armed, 0);

        // Level vs edge and source select
        I_source_sel = 1'b1;
        applyStimulus(0, 0, 0, 1);
        applyStimulus(1, 0, 0, 1);
        checkOutput("level_armed", O_armed, 1);
        applyStimulus(0, 0, 0, 1);
        applyStimulus(0, 0, 0, 1);
        checkOutput("level_no_fire", O_trig_out, 0);
        applyStimulus(0, 0, 1, 1);
        checkOutput("unsel_m3_no_fire", O_trig_out, 0);
        applyStimulus(0, 0, 0, 1);
        applyStimulus(0, 0, 1, 1);
        applyStimulus(0, 0, 1, 1);
        I_source_sel = 1'b0;
        applyStimulus(0, 0, 1, 1);
        checkOutput("sel_switch_no_fire", O_trig_out, 0);
        checkOutput("sel_switch_armed", O_armed, 1);
        I_source_sel = 1'b1;
        applyStimulus(0, 0, 1, 0);
        checkOutput("trace_drop_no_fire", O_trig_out, 0);
        applyStimulus(0, 0, 1, 1);
        checkOutput("trace_edge_fire", O_trig_out, 1);
        checkOutput("trace_edge_count", O_capture_count, 3);
        applyStimulus(0, 0, 0, 1);
        checkOutput("trace_pulse_end", O_trig_out, 0);
        checkOutput("trace_idle", O_armed, 0);

        // Holdoff with auto rearm; m3 toggles every cycle (an edge every 2 cycles)
        I_source_sel = 1'b0;
        I_trig_len   = 16'd3;
        I_holdoff    = 16'd4;
        I_auto_rearm = 1'b1;
        applyStimulus(1, 0, 0, 0);
        checkOutput("rearm_armed", O_armed, 1);
        for (int i = 1; i <= 16; i++) begin
            int phase;
            phase = (i - 1) % 8;
            applyStimulus(0, 0, 1'(i % 2), 0);
            checkOutput("rearm_trig", O_trig_out, (phase < 3) ? 1 : 0);
            checkOutput("rearm_busy", O_busy, (phase < 7) ? 1 : 0);
            checkOutput("rearm_armed_seq", O_armed, (phase == 7) ? 1 : 0);
        end
        checkOutput("rearm_count", O_capture_count, 5);
        applyStimulus(0, 1, 0, 0);
        checkOutput("rearm_disarm", O_armed, 0);

        // Abort in FIRE cycle 2 of 10 and disarm priority
        I_trig_len   = 16'd10;
        I_holdoff    = 16'd0;
        I_auto_rearm = 1'b0;
        applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 0, 1, 0);
        checkOutput("abort_c1", O_trig_out, 1);
        applyStimulus(0, 0, 1, 0);
        checkOutput("abort_c2", O_trig_out, 1);
        applyStimulus(0, 1, 1, 0);
        checkOutput("abort_trig", O_trig_out, 0);
        checkOutput("abort_busy", O_busy, 0);
        checkOutput("abort_armed", O_armed, 0);
        checkOutput("abort_count", O_capture_count, 6);
        applyStimulus(1, 1, 0, 0);
        checkOutput("arm_disarm_same", O_armed, 0);
        applyStimulus(1, 0, 0, 0);
        checkOutput("prio_armed", O_armed, 1);
        applyStimulus(0, 1, 1, 0);
        checkOutput("prio_no_fire", O_trig_out, 0);
        checkOutput("prio_idle", O_armed, 0);
        applyStimulus(0, 0, 1, 0);
        checkOutput("prio_still_idle", O_trig_out, 0);
        checkOutput("prio_count", O_capture_count, 6);

        // Reset mid-pulse at pulse cycle 10 of 100
        I_trig_len = 16'd100;
        applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 0, 1, 0);
        checkOutput("rst_mid_c1", O_trig_out, 1);
        checkOutput("rst_mid_count_pre", O_capture_count, 7);
        for (int i = 2; i <= 10; i++)
            applyStimulus(0, 0, 1, 0);
        checkOutput("rst_mid_c10", O_trig_out, 1);
        reset = 1'b1;
        applyStimulus(0, 0, 1, 0);
        reset = 1'b0;
        checkOutput("rst_mid_trig", O_trig_out, 0);
        checkOutput("rst_mid_busy", O_busy, 0);
        checkOutput("rst_mid_armed", O_armed, 0);
        checkOutput("rst_mid_count", O_capture_count, 0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("rst_mid_stays_idle", O_trig_out, 0);

        // Counter saturation, then clear coinciding with a fire
        I_trig_len   = 16'd0;
        I_auto_rearm = 1'b1;
        applyStimulus(1, 0, 0, 0);
        for (int i = 1; i <= 260; i++) begin
            applyStimulus(0, 0, 1, 0);
            applyStimulus(0, 0, 0, 0);
            if (i == 255)
                checkOutput("sat_count_255", O_capture_count, 255);
        end
        checkOutput("sat_count_260", O_capture_count, 255);
        checkOutput("sat_rearmed", O_armed, 1);
        I_clear_count = 1'b1;
        applyStimulus(0, 0, 1, 0);
        checkOutput("clear_fire_count", O_capture_count, 1);
        checkOutput("clear_fire_trig", O_trig_out, 1);
        applyStimulus(0, 0, 0, 0);
        I_clear_count = 1'b1;
        applyStimulus(0, 0, 0, 0);
        checkOutput("clear_only_count", O_capture_count, 0);
        applyStimulus(0, 1, 0, 0);
        checkOutput("final_idle", O_armed, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/trace_capture_sequencer.md
Name: trace_capture_sequencer

Overview:
Sequences trigger generation for the CW305 trace capture path. It arms on request from host-side registers and waits for a rising edge on one of two trigger sources: the M3 GPIO trigger or the trace-match trigger. It then drives a capture trigger pulse of programmable length, followed by a programmable holdoff. It sits between trace_top's trigger sources and the board trig_out pin, and replaces the static trigger-source mux.

Parameters:
pLEN_WIDTH, 16, width of trigger pulse length and holdoff counters
pCOUNT_WIDTH, 8, width of saturating capture counter

Ports:
trace_clk  input  1  sole clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
I_arm  input  1  single-cycle arm request
I_disarm  input  1  single-cycle disarm/abort request
I_source_sel  input  1  0 = M3 GPIO trigger, 1 = trace-match trigger
I_m3_trig  input  1  M3 GPIO trigger level, synchronous to trace_clk
I_trace_trig  input  1  trace-match trigger level, synchronous to trace_clk
I_trig_len  input  pLEN_WIDTH  trigger pulse length in cycles; 0 treated as 1
I_holdoff  input  pLEN_WIDTH  post-pulse holdoff in cycles; 0 = none
I_auto_rearm  input  1  1 = return to ARMED after holdoff, 0 = return to IDLE
I_clear_count  input  1  single-cycle clear of O_capture_count
O_trig_out  output  1  capture trigger to board pin
O_armed  output  1  high while in ARMED
O_busy  output  1  high while in FIRE or HOLDOFF
O_capture_count  output  pCOUNT_WIDTH  number of pulses started, saturating

Behaviour:
- Reset (synchronous, reset=1 at clock edge):
  - state=IDLE.
  - All outputs 0, counters 0, edge-history registers 0.
  - Reset overrides every other input, including mid-pulse; O_trig_out is 0 the cycle after reset is sampled.
- Edge detect:
  - Separate 1-cycle history registers for I_m3_trig and I_trace_trig, updated every cycle in every state.
  - edge = selected source is 1 now and its history is 0.
  - Changing I_source_sel never by itself creates an edge.
  - A source already high when arming does not fire; a fresh 0->1 transition is required.
- States: IDLE, ARMED, FIRE, HOLDOFF; all outputs registered.
- IDLE:
  - I_arm=1 and I_disarm=0 -> ARMED.
  - O_armed=1 from the next cycle.
- ARMED:
  - I_disarm=1 -> IDLE; disarm takes priority over a same-cycle edge.
  - Otherwise, edge -> FIRE. Latch len=max(I_trig_len,1) and I_holdoff, and increment O_capture_count (saturate at all-ones).
- FIRE:
  - O_trig_out=1 for exactly len cycles, first high cycle being the cycle after the edge was sampled (latency 1).
  - On the last cycle: holdoff_latched=0 -> go straight to the exit decision; otherwise -> HOLDOFF.
  - I_disarm in FIRE aborts: O_trig_out=0 next cycle, state=IDLE; count is not decremented.
- HOLDOFF:
  - O_trig_out=0 for exactly holdoff_latched cycles.
  - Edges are ignored.
  - I_disarm -> IDLE next cycle.
- Exit decision, evaluated when FIRE or HOLDOFF completes:
  - I_auto_rearm=1 -> ARMED; else -> IDLE.
  - An edge on the first ARMED cycle after rearm is honoured.
- I_arm outside IDLE is ignored.
- I_trig_len and I_holdoff changes after latching have no effect on the pulse in progress.
- I_clear_count clears O_capture_count next cycle. If it coincides with a fire, the result is 1; clear applies first, then increment.
- O_busy = (state==FIRE || state==HOLDOFF).
- O_armed = (state==ARMED).

Test Plan:
- Reset mid-pulse: trig_len=100, fire, assert reset at pulse cycle 10 -> O_trig_out=0 next cycle, state IDLE, count=0.
- Basic fire: arm, sel=0, I_m3_trig 0->1 at cycle N, trig_len=5, holdoff=0, auto_rearm=0 -> O_trig_out high cycles N+1..N+5, IDLE at N+6, count=1; trig_len=0 run -> 1-cycle pulse.
- Level vs edge and source select: hold I_trace_trig=1, arm with sel=1 -> no pulse; drop then raise -> pulse. Toggle I_m3_trig while sel=1 -> no pulse.
- Holdoff and rearm: trig_len=3, holdoff=4, auto_rearm=1, edges every 2 cycles -> pulses spaced exactly 7 cycles apart (plus the rearm-to-edge gap), intermediate edges ignored, O_busy high 7 cycles per pulse.
- Abort and priority: disarm during FIRE cycle 2 of 10 -> trig_out low next cycle, IDLE. Arm+disarm same cycle -> stays IDLE. Disarm with edge in ARMED -> no pulse.
- Counter saturation and clear: pCOUNT_WIDTH=8, 260 fires -> count=255; clear coinciding with fire -> count=1.
